alu_sequencer: RTL and testbench

- EX-stage controller wrapped around the ALU datapath.
- Accepts one operation per handshake from the ID/EX register.
- Completes AND/OR/NOT/ADD/SUB/CMP in one cycle.
- Runs MUL and DIV as 32-iteration shift-add / restoring-divide sequences, holding the pipeline stalled until they finish.
- Result, remainder and status are registered for the EX/MEM register.

---
 rtl/alu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// EX-stage sequencer around the ALU: single-cycle logic/arithmetic ops,
// multi-cycle shift-add MUL and restoring DIV with pipeline stall.
module alu_sequencer #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [4:0]       alu_control,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             result_valid,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             illegal_op,
   output logic [3:0]       flag,
   output logic             stall
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   localparam logic [4:0] OP_ADD = 5'd0, OP_ADDI = 5'd1, OP_SUB = 5'd2, OP_SUBI = 5'd3,
                          OP_MUL = 5'd4, OP_DIV  = 5'd5, OP_AND = 5'd6, OP_ANDI = 5'd7,
                          OP_OR  = 5'd8, OP_ORI  = 5'd9, OP_NOT = 5'd10, OP_CMP = 5'd11;

   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

   state_t            state, state_n;
   logic [CW-1:0]     count;
   logic [WIDTH-1:0]  opnd_a, opnd_b;
   logic [WIDTH-1:0]  acc_hi, acc_lo;
   logic              accept, to_mul, to_div;

   logic [WIDTH-1:0]  s_res, s_rem;
   logic              s_ovf, s_dbz, s_ill;
   logic [3:0]        s_flag;
   logic signed [WIDTH-1:0] sa, sb;

   logic [WIDTH:0]    mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0]  mul_hi_n, mul_lo_n, div_rem_n, div_quo_n;

   assign issue_ready = (state == IDLE) && !flush;
   assign stall       = (state != IDLE);
   assign accept      = issue_valid && issue_ready;
   assign to_mul      = (alu_control == OP_MUL);
   assign to_div      = (alu_control == OP_DIV) && (data_b != '0);

   // Single-cycle results, computed straight from the issue inputs.
   always_comb begin
      s_res  = '0;
      s_rem  = '0;
      s_ovf  = 1'b0;
      s_dbz  = 1'b0;
      s_ill  = 1'b0;
      s_flag = '0;
      sa     = data_a;
      sb     = data_b;
      case (alu_control)
         OP_ADD, OP_ADDI: {s_ovf, s_res} = {1'b0, data_a} + {1'b0, data_b};
         OP_SUB, OP_SUBI: {s_ovf, s_res} = {1'b0, data_a} - {1'b0, data_b};
         OP_MUL:          s_res = '0;
         OP_DIV: begin
            s_res = '1;
            s_rem = data_a;
            s_dbz = 1'b1;
         end
         OP_AND, OP_ANDI: s_res = data_a & data_b;
         OP_OR, OP_ORI:   s_res = data_a | data_b;
         OP_NOT:          s_res = ~data_a;
         OP_CMP: begin
            s_flag = {data_a == data_b, data_a < data_b, sa < sb, 1'b0};
            s_res  = {{(WIDTH-4){1'b0}}, s_flag};
         end
         default:         s_ill = 1'b1;
      endcase
   end

   // One iteration of each sequence: {acc_hi,acc_lo} is the product for MUL,
   // and {partial remainder, shifting dividend/quotient} for DIV.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_a} : '0);
      mul_hi_n  = mul_sum[WIDTH:1];
      mul_lo_n  = {mul_sum[0], acc_lo[WIDTH-1:1]};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_b};
      if (div_diff[WIDTH]) begin
         div_rem_n = div_shift[WIDTH-1:0];
         div_quo_n = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
         div_rem_n = div_diff[WIDTH-1:0];
         div_quo_n = {acc_lo[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept && to_mul)      state_n = MUL_RUN;
            else if (accept && to_div) state_n = DIV_RUN;
         end
         MUL_RUN, DIV_RUN: begin
            if (flush || count == LAST) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count        <= '0;
         result       <= '0;
         remainder    <= '0;
         flag         <= '0;
         result_valid <= 1'b0;
         overflow     <= 1'b0;
         div_by_zero  <= 1'b0;
         illegal_op   <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  count  <= '0;
                  opnd_a <= data_a;
                  opnd_b <= data_b;
                  acc_hi <= '0;
                  acc_lo <= to_mul ? data_b : data_a;
                  if (!to_mul && !to_div) begin
                     result       <= s_res;
                     remainder    <= s_rem;
                     overflow     <= s_ovf;
                     div_by_zero  <= s_dbz;
                     illegal_op   <= s_ill;
                     flag         <= s_flag;
                     result_valid <= 1'b1;
                  end
               end
            end
            MUL_RUN, DIV_RUN: begin
               if (!flush) begin
                  count  <= count + 1'b1;
                  acc_hi <= (state == MUL_RUN) ? mul_hi_n : div_rem_n;
                  acc_lo <= (state == MUL_RUN) ? mul_lo_n : div_quo_n;
                  if (count == LAST) begin
                     result       <= (state == MUL_RUN) ? mul_lo_n : div_quo_n;
                     remainder    <= (state == MUL_RUN) ? '0 : div_rem_n;
                     overflow     <= (state == MUL_RUN) ? |mul_hi_n : 1'b0;
                     div_by_zero  <= 1'b0;
                     illegal_op   <= 1'b0;
                     flag         <= '0;
                     result_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: hand-computed vectors checked with
// immediate assertions, one linear stimulus sequence.
module tb_alu_sequencer;

   logic        clock = 1'b0;
   logic        reset, flush, issue_valid, issue_ready;
   logic [4:0]  alu_control;
   logic [31:0] data_a, data_b, result, remainder;
   logic        result_valid, overflow, div_by_zero, illegal_op, stall;
   logic [3:0]  flag;
   int          total = 0;
   int          bad   = 0;
   int          n;
   int          rv_seen;

   alu_sequencer #(.WIDTH(32), .ITER(32)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .alu_control(alu_control), .data_a(data_a), .data_b(data_b),
      .result(result), .remainder(remainder), .result_valid(result_valid),
      .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op),
      .flag(flag), .stall(stall)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_control = op;
      data_a      = a;
      data_b      = b;
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
      data_a      = 32'hDEAD_BEEF;
      data_b      = 32'h1234_5678;
   endtask

   // Counts cycles the sequencer stays busy after the accepting edge.
   task automatic run_long(output int cycles);
      cycles = 0;
      while (stall && !issue_ready && cycles < 100) begin
         cycles++;
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; issue_valid = 1'b0;
      alu_control = '0; data_a = '0; data_b = '0;
      tick(); tick();
      check("rst_result", result, 32'h0);
      check("rst_rv", result_valid, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_status", {overflow, div_by_zero, illegal_op, flag}, 7'h0);
      reset = 1'b0;
      #1;
      check("rst_ready", issue_ready, 1'b1);

      issue(5'd0, 32'hFFFF_FFFF, 32'h1);
      check("add_rv", result_valid, 1'b1);
      check("add_res", result, 32'h0);
      check("add_ovf", overflow, 1'b1);
      check("add_stall", stall, 1'b0);
      tick();
      check("add_rv_pulse", result_valid, 1'b0);

      issue(5'd4, 32'h0001_0000, 32'h0001_0000);
      run_long(n);
      check("mul_busy_cycles", n, 32);
      check("mul_rv", result_valid, 1'b1);
      check("mul_res", result, 32'h0);
      check("mul_ovf", overflow, 1'b1);

      issue(5'd4, 32'd7, 32'd6);
      run_long(n);
      check("mul76_res", result, 32'd42);
      check("mul76_ovf", overflow, 1'b0);

      issue(5'd5, 32'd100, 32'd7);
      run_long(n);
      check("div_busy_cycles", n, 32);
      check("div_rv", result_valid, 1'b1);
      check("div_quo", result, 32'd14);
      check("div_rem", remainder, 32'd2);
      check("div_dbz", div_by_zero, 1'b0);

      issue(5'd5, 32'd5, 32'd0);
      check("dbz_stall", stall, 1'b0);
      check("dbz_rv", result_valid, 1'b1);
      check("dbz_res", result, 32'hFFFF_FFFF);
      check("dbz_rem", remainder, 32'd5);
      check("dbz_flag", div_by_zero, 1'b1);

      alu_control = 5'd11; data_a = 32'd5; data_b = 32'd5; issue_valid = 1'b1;
      tick();
      check("cmp_eq_flag", flag, 4'b1000);
      check("cmp_eq_res", result, 32'd8);
      check("cmp_rem_cleared", remainder, 32'd0);
      check("cmp_dbz_cleared", div_by_zero, 1'b0);
      data_a = 32'hFFFF_FFFF; data_b = 32'd1;
      tick();
      check("cmp_sgn_flag", flag, 4'b0010);
      check("b2b_rv", result_valid, 1'b1);
      issue_valid = 1'b0;

      issue(5'd12, 32'd9, 32'd9);
      check("ill_flag", illegal_op, 1'b1);
      check("ill_res", result, 32'h0);

      issue(5'd2, 32'd3, 32'd5);
      check("sub_res", result, 32'hFFFF_FFFE);
      check("sub_borrow", overflow, 1'b1);
      check("sub_ill_cleared", illegal_op, 1'b0);

      flush = 1'b1;
      #1;
      check("flush_blocks_ready", issue_ready, 1'b0);
      issue(5'd0, 32'd1, 32'd1);
      flush = 1'b0;
      check("flush_no_accept_rv", result_valid, 1'b0);
      check("flush_no_accept_res", result, 32'hFFFF_FFFE);

      issue(5'd4, 32'd7, 32'd6);
      repeat (10) tick();
      check("mul_mid_stall", stall, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("flush_ready", issue_ready, 1'b1);
      check("flush_rv", result_valid, 1'b0);
      check("flush_res_kept", result, 32'hFFFF_FFFE);
      rv_seen = 0;
      repeat (40) begin
         tick();
         if (result_valid) rv_seen++;
      end
      check("flush_no_late_rv", rv_seen, 0);

      issue(5'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      check("and_res", result, 32'h00F0_00F0);
      check("and_rv", result_valid, 1'b1);

      issue(5'd5, 32'd100, 32'd7);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstmid_res", result, 32'h0);
      check("rstmid_rem", remainder, 32'h0);
      check("rstmid_stall", stall, 1'b0);
      check("rstmid_rv", result_valid, 1'b0);
      issue(5'd0, 32'd2, 32'd3);
      check("add23_res", result, 32'd5);
      check("add23_rv", result_valid, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
